// File: rtl/flex_counter.sv
// Purpose : programmable up-counter that rolls over to 1 after reaching rollover_val, with a registered terminal-count flag.
// Latency : one clk edge from clear/count_enable/rollover_val to count_out and rollover_flag; both outputs come straight from registers.
// Backpressure: none; count_enable low simply holds the count and the flag.
//
// Ports:
//   clk           - single clock, all state changes on its rising edge
//   nrst          - synchronous reset, active-high despite the name; beats clear and count_enable
//   clear         - synchronous clear to 0, beats count_enable
//   count_enable  - advance the count at the next edge
//   rollover_val  - terminal count value (unsigned, NUM_BITS wide)
//   count_out     - current count (register output)
//   rollover_flag - high while count_out equals rollover_val (register output)
module flex_counter #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                clear,
    input  logic                count_enable,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count_out,
    output logic                rollover_flag
);

    localparam logic [NUM_BITS-1:0] ONE = {{(NUM_BITS-1){1'b0}}, 1'b1};

    logic [NUM_BITS-1:0] r_count;
    logic                r_flag;
    logic [NUM_BITS-1:0] w_next_count;
    logic                w_next_flag;

    always_comb begin
        w_next_count = r_count;
        if (clear) begin
            w_next_count = '0;
        end else if (count_enable) begin
            // Terminal count restarts at 1, not 0; every other value wraps
            // naturally modulo 2^NUM_BITS.
            if (r_count == rollover_val) begin
                w_next_count = ONE;
            end else begin
                w_next_count = r_count + ONE;
            end
        end
        // Comparing against the next count (rather than the current one)
        // keeps the flag aligned with count_out instead of a cycle behind.
        // It is evaluated even when holding, so a change of rollover_val
        // shows up at the following edge.
        w_next_flag = clear ? 1'b0 : (w_next_count == rollover_val);
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_count <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_flag  <= w_next_flag;
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_flag;

endmodule

// File: tb/tb_flex_counter.sv
// Purpose : directed self-checking bench for flex_counter (NUM_BITS=4).
// Latency : inputs driven on the falling edge, outputs sampled on the next falling edge (one rising edge later).
// Backpressure: not applicable.
module tb_flex_counter;

    logic       clk;
    logic       nrst;
    logic       clear;
    logic       count_enable;
    logic [3:0] rollover_val;
    logic [3:0] count_out;
    logic       rollover_flag;

    int n_checks = 0;
    int n_fail   = 0;

    flex_counter #(.NUM_BITS(4)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .clear        (clear),
        .count_enable (count_enable),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; returns at a falling edge where inputs may be
    // changed and outputs sampled safely.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        nrst = 1'b1;
        tick(1);
        nrst = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b1; clear = 1'b0; count_enable = 1'b1; rollover_val = 4'd15;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            n_checks++;
            if ({count_out, rollover_flag} !== {4'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_edge%0d: count=%0d flag=%0b, want count=0 flag=0", i, count_out, rollover_flag);
            end
        end
        nrst = 1'b0; count_enable = 1'b0;
        #1;
        n_checks++;
        if ({count_out, rollover_flag} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: count=%0d flag=%0b, want count=0 flag=0", count_out, rollover_flag);
        end
        tick(1);
        n_checks++;
        if ({count_out, rollover_flag} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle: count=%0d flag=%0b, want count=0 flag=0", count_out, rollover_flag);
        end
    endtask

    task automatic test_count();
        apply_reset();
        rollover_val = 4'd13; count_enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            n_checks++;
            if ({count_out, rollover_flag} !== {4'(i), 1'b0}) begin
                n_fail++;
                $display("FAIL count_step%0d: count=%0d flag=%0b, want count=%0d flag=0", i, count_out, rollover_flag, i);
            end
        end
    endtask

    task automatic test_rollover();
        apply_reset();
        rollover_val = 4'd11; count_enable = 1'b1;
        tick(11);
        n_checks++;
        if ({count_out, rollover_flag} !== {4'd11, 1'b1}) begin
            n_fail++;
            $display("FAIL rollover_at_11: count=%0d flag=%0b, want count=11 flag=1", count_out, rollover_flag);
        end
        tick(1);
        n_checks++;
        if ({count_out, rollover_flag} !== {4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL rollover_wrap: count=%0d flag=%0b, want count=1 flag=0", count_out, rollover_flag);
        end
    endtask

    task automatic test_clear();
        apply_reset();
        rollover_val = 4'd9; count_enable = 1'b1;
        tick(7);
        n_checks++;
        if ({count_out, rollover_flag} !== {4'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_pre: count=%0d flag=%0b, want count=7 flag=0", count_out, rollover_flag);
        end
        clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            n_checks++;
            if ({count_out, rollover_flag} !== {4'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL clear_edge%0d: count=%0d flag=%0b, want count=0 flag=0", i, count_out, rollover_flag);
            end
        end
        clear = 1'b0;
        tick(9);
        n_checks++;
        if ({count_out, rollover_flag} !== {4'd9, 1'b1}) begin
            n_fail++;
            $display("FAIL clear_post: count=%0d flag=%0b, want count=9 flag=1", count_out, rollover_flag);
        end
    endtask

    // Continues from the end state of test_clear (count 9, flag 1).
    task automatic test_hold();
        count_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            n_checks++;
            if ({count_out, rollover_flag} !== {4'd9, 1'b1}) begin
                n_fail++;
                $display("FAIL hold_edge%0d: count=%0d flag=%0b, want count=9 flag=1", i, count_out, rollover_flag);
            end
        end
    endtask

    // Flag tracks a changed rollover_val one edge later while holding.
    task automatic test_rv_change();
        rollover_val = 4'd5;
        tick(1);
        n_checks++;
        if ({count_out, rollover_flag} !== {4'd9, 1'b0}) begin
            n_fail++;
            $display("FAIL rv_change_off: count=%0d flag=%0b, want count=9 flag=0", count_out, rollover_flag);
        end
        rollover_val = 4'd9;
        tick(1);
        n_checks++;
        if ({count_out, rollover_flag} !== {4'd9, 1'b1}) begin
            n_fail++;
            $display("FAIL rv_change_on: count=%0d flag=%0b, want count=9 flag=1", count_out, rollover_flag);
        end
    endtask

    task automatic test_priority();
        // From count 9: reset, clear and enable together.
        nrst = 1'b1; clear = 1'b1; count_enable = 1'b1;
        tick(1);
        n_checks++;
        if ({count_out, rollover_flag} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_all: count=%0d flag=%0b, want count=0 flag=0", count_out, rollover_flag);
        end
        nrst = 1'b0; clear = 1'b0; count_enable = 1'b1;
        tick(3);
        n_checks++;
        if ({count_out, rollover_flag} !== {4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_count3: count=%0d flag=%0b, want count=3 flag=0", count_out, rollover_flag);
        end
        clear = 1'b1; count_enable = 1'b0;
        tick(1);
        n_checks++;
        if ({count_out, rollover_flag} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_clear_only: count=%0d flag=%0b, want count=0 flag=0", count_out, rollover_flag);
        end
        // Reset mid-count with enable high must win outright.
        clear = 1'b0; count_enable = 1'b1;
        tick(5);
        nrst = 1'b1;
        tick(1);
        nrst = 1'b0; count_enable = 1'b0;
        n_checks++;
        if ({count_out, rollover_flag} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_mid_reset: count=%0d flag=%0b, want count=0 flag=0", count_out, rollover_flag);
        end
    endtask

    // rollover_val=0: 1..15 then natural wrap to 0 with flag, then back to 1.
    task automatic test_rv_zero();
        logic [3:0] exp_c;
        apply_reset();
        rollover_val = 4'd0; count_enable = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            exp_c = 4'(i);
            tick(1);
            n_checks++;
            if ({count_out, rollover_flag} !== {exp_c, (exp_c == 4'd0)}) begin
                n_fail++;
                $display("FAIL rv_zero_step%0d: count=%0d flag=%0b, want count=%0d flag=%0b",
                         i, count_out, rollover_flag, exp_c, (exp_c == 4'd0));
            end
        end
    endtask

    initial begin
        nrst = 1'b1; clear = 1'b0; count_enable = 1'b0; rollover_val = 4'd15;
        test_reset();
        test_count();
        test_rollover();
        test_clear();
        test_hold();
        test_rv_change();
        test_priority();
        test_rv_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flex_counter.md
FLEX_COUNTER -- requirements
Module: flex_counter

Interface
- REQ-001: Parameter NUM_BITS, default 4, sets the width of the counter, the rollover value and the count output.
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: nrst  input  1  reset; synchronous and active-high (nrst=1 at a rising clk edge resets the block).
- REQ-004: clear  input  1  synchronous clear; 1 forces the count to 0 at the next rising edge.
- REQ-005: count_enable  input  1  1 allows the count to advance at the next rising edge.
- REQ-006: rollover_val  input  NUM_BITS  terminal count value, unsigned.
- REQ-007: count_out  output  NUM_BITS  current count, driven directly from a register.
- REQ-008: rollover_flag  output  1  registered flag, high while count_out equals rollover_val.

Function
- REQ-009: The block SHALL hold two registers, the count and the flag, and both SHALL update only on the rising edge of clk.
- REQ-010: Next-count priority: nrst first, then clear, then count_enable, otherwise hold.
- REQ-011: With clear=1 and nrst=0, the next count SHALL be 0 and the next flag SHALL be 0, regardless of count_enable.
- REQ-012: With count_enable=1 and clear=0, if count_out equals rollover_val, the next count SHALL be 1; the counter rolls over to 1, not 0.
- REQ-013: Otherwise, with count_enable=1 and clear=0, the next count SHALL be count_out+1, modulo 2^NUM_BITS.
- REQ-014: With count_enable=0 and clear=0, count_out SHALL hold its value.
- REQ-015: Outside reset and clear, the next flag SHALL be (next count == rollover_val), evaluated every cycle whether or not enabled.
- REQ-016: As a result of REQ-015, rollover_flag is high in exactly the cycles where count_out equals rollover_val; it adds no extra cycle of latency relative to count_out.
- REQ-017: If count_enable drops while count_out equals rollover_val, count_out and rollover_flag=1 SHALL both hold.
- REQ-018: If rollover_val changes, the flag SHALL reflect the new comparison at the next rising edge.
- REQ-019: rollover_val=0 case: from count 0 with enable, the next count is 1. The count then runs up to 2^NUM_BITS-1, wraps naturally to 0, and the flag is 1 at 0.
- REQ-020: The count SHALL start from 0 after reset or clear, so the first enabled edge produces 1.
- REQ-021: No combinational path SHALL exist from any input to either output.

Reset
- REQ-022: While nrst=1 at a rising edge, count_out SHALL become 0 and rollover_flag SHALL become 0, overriding clear and count_enable.
- REQ-023: Both outputs SHALL stay 0 for every edge at which nrst remains 1, and after nrst is deasserted until an enabled edge occurs.
- REQ-024: Reset asserted mid-count SHALL take effect at the next rising edge, with no partial update.
- REQ-025: Before the first reset, output values are unspecified; the bench SHALL apply reset before any check.

Verification
- REQ-026: Reset with count_enable=1 and rollover_val=15 held for 2 edges, then released -> count_out=0 and rollover_flag=0 during reset and right after release.
- REQ-027: After reset, enable with rollover_val=13 for 10 edges -> count_out=10, rollover_flag=0.
- REQ-028: After reset, enable with rollover_val=11 -> after 11 edges count_out=11 and rollover_flag=1; after 1 more edge count_out=1 and rollover_flag=0.
- REQ-029: Enable with rollover_val=9; after 7 edges count_out=7; assert clear for 2 edges -> count_out=0 and rollover_flag=0 even with enable high. Release clear; after 9 more edges count_out=9 and rollover_flag=1.
- REQ-030: From the end state of REQ-029, deassert count_enable for 5 edges -> count_out stays 9 and rollover_flag stays 1.
- REQ-031: With count_enable=1, clear=1 and nrst=1 together -> outputs 0. With clear=1 only -> outputs 0. With count_enable=1 and rollover_val=0 -> the count sequence is 1, 2, …, 15, 0, and the flag is 1 only at 0.
